instr_queue: RTL and testbench
==============================

# instr_queue

Instruction queue between the fetch stage and the decode stage. It buffers up to DEPTH fetched instructions, each with its PC, PC+2 and memory-error flag. When the queue fills it back-pressures fetch through its stall input. It drops all buffered work on a taken branch or jump, and stops accepting instructions after a HALT or an instruction-memory error has been enqueued.

## Interface
- DEPTH, 4, number of entries; power of two, 2..16
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- push  in  1  fetch presents a valid instruction this cycle
- in_instr  in  16  fetched instruction word
- in_pc  in  16  PC of in_instr
- in_pc_inc  in  16  PC+2 of in_instr
- in_err  in  1  instruction-memory error on this fetch
- full  out  1  count == DEPTH; drives the fetch stall input
- flush  in  1  PCsrc from the resolving stage; discard all entries
- pop  in  1  decode consumes the head entry this cycle
- out_valid  out  1  head entry present (count != 0)
- out_instr  out  16  head instruction; 16'h0800 (NOP) when empty
- out_pc, out_pc_inc  out  16 each  head PC and PC+2; 16'h0000 when empty
- out_err  out  1  head entry's error flag; 0 when empty
- locked  out  1  a HALT or error entry has been accepted; further pushes are dropped
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Storage is a circular buffer with a write pointer and a read pointer, each $clog2(DEPTH) bits wide. Both wrap modulo DEPTH.
- Push is accepted when push & ~full & ~locked & ~flush.
  - The entry is written at wr_ptr, then wr_ptr increments.
- Pop is accepted when pop & out_valid & ~flush. rd_ptr increments.
  - pop while empty is ignored.
- Push and pop accepted together: count is unchanged and both pointers advance.
- A full queue rejects push even when pop is accepted in the same cycle. There is no same-cycle slot reuse.
- Lock:
  - Set when an accepted entry has in_instr[15:11] == 5'b00000 (HALT) or in_err == 1.
  - The HALT or error entry itself is stored and delivered normally.
  - Cleared only by flush or reset.
- Flush takes priority over push and pop in the same cycle. It sets wr_ptr = rd_ptr = 0, count = 0 and locked = 0. The in_* values presented that cycle are discarded.
- Head outputs are a combinational read of the entry at rd_ptr, masked to the empty values (NOP/0/0) when count == 0.
- Rejected pushes are silently dropped. Fetch holds its PC while full is high, so nothing is lost.

## Timing
- Reset (rst low, asynchronous):
  - pointers = 0, count = 0, locked = 0
  - full = 0, out_valid = 0, out_instr = 16'h0800, out_pc = out_pc_inc = 0, out_err = 0
  - Storage contents are don't-care.
- Latency:
  - An entry pushed at edge N appears on out_* after edge N; decode can pop it in cycle N+1.
  - No fall-through: an entry pushed into an empty queue is not visible in the same cycle.
- full, out_valid, locked and count are derived from registered state only. No combinational path runs from push or pop to full.
- A flush in cycle N yields count == 0 after edge N. The first accepted post-flush push is in cycle N+1.
- Wrap-around: after DEPTH pushes and DEPTH pops, pointers return to 0 and ordering is preserved.

## Structure
- Shared package `proc_pkg`:
  - NOP_INSTR = 16'h0800
  - OP_HALT = 5'b00000
  - IQ entry layout {err, pc_inc[15:0], pc[15:0], instr[15:0]}, 49 bits
- Sub-module `iq_storage`: DEPTH × 49 register array with synchronous write (we, waddr) and asynchronous read (raddr). No reset on the array.
- Pointer, count and lock logic live in instr_queue.

## Test plan
- Reset then 4 pushes (instr 16'h4001..16'h4004, pc 0,2,4,6), no pop:
  - count = 4, full = 1.
  - A 5th push is dropped.
  - 4 pops return 16'h4001..16'h4004 in order, with out_pc 0,2,4,6.
  - Then out_valid = 0 and out_instr = 16'h0800.
- Steady push+pop every cycle for 10 cycles starting from count = 1: count stays 1 and pointers wrap twice with no reordering.
- Queue holds 3 entries; flush asserted together with push and pop:
  - Next cycle count = 0, out_valid = 0.
  - The pushed instruction never appears at the output.
- Push 16'h0000 (HALT) then 16'h4005:
  - locked = 1 after the HALT push, and 16'h4005 is dropped.
  - HALT is popped normally.
  - flush clears locked; the next push is accepted.
- Push with in_err = 1: entry delivered with out_err = 1, locked = 1, subsequent pushes dropped until flush.
- rst pulsed low asynchronously mid-cycle with count = 2: outputs immediately show the reset values listed under Timing, with no clock edge needed.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: NOP/HALT encodings and the instruction-queue entry layout.
package proc_pkg;

    localparam logic [15:0] NOP_INSTR  = 16'h0800;
    localparam logic [4:0]  OP_HALT    = 5'b00000;
    localparam int          IQ_ENTRY_W = 49;

    typedef struct packed {
        logic        err;
        logic [15:0] pc_inc;
        logic [15:0] pc;
        logic [15:0] instr;
    } iq_entry_t;

    // An entry that must stop further fetch: a HALT opcode or a failed fetch.
    function automatic logic is_lock_entry(input logic [15:0] instr, input logic err);
        return (instr[15:11] == OP_HALT) || err;
    endfunction

endpackage

// File: rtl/iq_storage.sv
// Entry array for the instruction queue: synchronous write, asynchronous read, no reset.
module iq_storage
    import proc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  iq_entry_t     wdata,
    input  logic [AW-1:0] raddr,
    output iq_entry_t     rdata
);

    iq_entry_t mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue with back-pressure, flush on taken branch and lock after HALT/error.
module instr_queue
    import proc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [15:0]                in_instr,
    input  logic [15:0]                in_pc,
    input  logic [15:0]                in_pc_inc,
    input  logic                       in_err,
    output logic                       full,
    input  logic                       flush,
    input  logic                       pop,
    output logic                       out_valid,
    output logic [15:0]                out_instr,
    output logic [15:0]                out_pc,
    output logic [15:0]                out_pc_inc,
    output logic                       out_err,
    output logic                       locked,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          locked_reg, locked_next;

    logic          push_ok;
    logic          pop_ok;
    iq_entry_t     wr_entry;
    iq_entry_t     rd_entry;

    assign full      = (count_reg == CW'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign locked    = locked_reg;
    assign count     = count_reg;

    // A full queue never reuses the slot freed by a same-cycle pop.
    assign push_ok = push & ~full & ~locked_reg & ~flush;
    assign pop_ok  = pop & out_valid & ~flush;

    assign wr_entry = {in_err, in_pc_inc, in_pc, in_instr};

    iq_storage #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_reg),
        .wdata (wr_entry),
        .raddr (rd_ptr_reg),
        .rdata (rd_entry)
    );

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        locked_next = locked_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            locked_next = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
                if (is_lock_entry(in_instr, in_err)) begin
                    locked_next = 1'b1;
                end
            end
            if (pop_ok) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            locked_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            locked_reg <= locked_next;
        end
    end

    // Head is masked to a NOP bubble whenever the queue is empty.
    assign out_instr  = out_valid ? rd_entry.instr  : NOP_INSTR;
    assign out_pc     = out_valid ? rd_entry.pc     : 16'h0000;
    assign out_pc_inc = out_valid ? rd_entry.pc_inc : 16'h0000;
    assign out_err    = out_valid ? rd_entry.err    : 1'b0;

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios plus random traffic against a queue-based model.
module tb_instr_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push = 1'b0;
    logic [15:0]   in_instr = '0;
    logic [15:0]   in_pc = '0;
    logic [15:0]   in_pc_inc = '0;
    logic          in_err = 1'b0;
    logic          full;
    logic          flush = 1'b0;
    logic          pop = 1'b0;
    logic          out_valid;
    logic [15:0]   out_instr;
    logic [15:0]   out_pc;
    logic [15:0]   out_pc_inc;
    logic          out_err;
    logic          locked;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_pc_inc  (in_pc_inc),
        .in_err     (in_err),
        .full       (full),
        .flush      (flush),
        .pop        (pop),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_pc_inc (out_pc_inc),
        .out_err    (out_err),
        .locked     (locked),
        .count      (count)
    );

    typedef struct packed {
        logic        err;
        logic [15:0] pc_inc;
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    ent_t mq[$];
    bit   m_locked = 1'b0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [48:0] exp_head;
        int          n;
        n = mq.size();
        exp_head = (n > 0) ? mq[0] : {1'b0, 16'h0000, 16'h0000, 16'h0800};
        chk({tag, ".count"}, 64'(count), 64'(n));
        chk({tag, ".full"}, 64'(full), 64'(n == DEPTH));
        chk({tag, ".valid"}, 64'(out_valid), 64'(n != 0));
        chk({tag, ".locked"}, 64'(locked), 64'(m_locked));
        chk({tag, ".head"}, 64'({out_err, out_pc_inc, out_pc, out_instr}), 64'(exp_head));
    endtask

    // One clock cycle of stimulus; the model is advanced from the pre-edge state.
    task automatic cycle(input bit p, input logic [15:0] i, input logic [15:0] pc,
                         input bit e, input bit po, input bit fl, input string tag);
        bit   push_acc;
        bit   pop_acc;
        ent_t ent;
        push = p; in_instr = i; in_pc = pc; in_pc_inc = pc + 16'd2; in_err = e;
        pop = po; flush = fl;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_locked = 1'b0;
        end else begin
            push_acc = p && (mq.size() < DEPTH) && !m_locked;
            pop_acc  = po && (mq.size() > 0);
            if (pop_acc) void'(mq.pop_front());
            if (push_acc) begin
                ent = '{err: e, pc_inc: pc + 16'd2, pc: pc, instr: i};
                mq.push_back(ent);
                if (i[15:11] == 5'd0 || e) m_locked = 1'b1;
            end
        end
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; in_err = 1'b0;
        check_all(tag);
        $display("%s push=%0b instr=%h err=%0b pop=%0b flush=%0b -> count=%0d head=%h locked=%0b",
                 tag, p, i, e, po, fl, count, out_instr, locked);
    endtask

    initial begin
        logic [15:0] ri;
        bit          rp, rpo, rfl, re;

        // Reset state
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Fill to full, overflow, drain
        for (int k = 0; k < 4; k++)
            cycle(1, 16'h4001 + 16'(k), 16'(2 * k), 0, 0, 0, "t1.push");
        chk("t1.full_after4", 64'(full), 64'd1);
        cycle(1, 16'h4099, 16'h0008, 0, 0, 0, "t1.push5");
        chk("t1.count_after5", 64'(count), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t1.order_instr", 64'(out_instr), 64'(16'h4001 + 16'(k)));
            chk("t1.order_pc", 64'(out_pc), 64'(2 * k));
            cycle(0, 16'h0, 16'h0, 0, 1, 0, "t1.pop");
        end
        chk("t1.empty_nop", 64'(out_instr), 64'h0800);
        cycle(0, 16'h0, 16'h0, 0, 1, 0, "t1.pop_empty");

        // Steady push+pop from count 1
        cycle(1, 16'h4100, 16'h0100, 0, 0, 0, "t2.seed");
        for (int k = 0; k < 10; k++)
            cycle(1, 16'h4101 + 16'(k), 16'h0102 + 16'(2 * k), 0, 1, 0, "t2.pp");
        chk("t2.count_stays1", 64'(count), 64'd1);
        chk("t2.last_head", 64'(out_instr), 64'h410a);
        cycle(0, 16'h0, 16'h0, 0, 1, 0, "t2.drain");

        // Flush beats push and pop
        for (int k = 0; k < 3; k++)
            cycle(1, 16'h4200 + 16'(k), 16'h0200 + 16'(2 * k), 0, 0, 0, "t3.push");
        cycle(1, 16'h4777, 16'h0300, 0, 1, 1, "t3.flush");
        chk("t3.count0", 64'(count), 64'd0);
        chk("t3.valid0", 64'(out_valid), 64'd0);
        cycle(0, 16'h0, 16'h0, 0, 0, 0, "t3.idle");

        // HALT locks the queue
        cycle(1, 16'h0000, 16'h0400, 0, 0, 0, "t4.halt");
        chk("t4.locked", 64'(locked), 64'd1);
        cycle(1, 16'h4005, 16'h0402, 0, 0, 0, "t4.dropped");
        chk("t4.count1", 64'(count), 64'd1);
        cycle(0, 16'h0, 16'h0, 0, 1, 0, "t4.pop_halt");
        cycle(0, 16'h0, 16'h0, 0, 0, 1, "t4.flush");
        chk("t4.unlocked", 64'(locked), 64'd0);
        cycle(1, 16'h4006, 16'h0500, 0, 0, 0, "t4.accept");
        chk("t4.accepted", 64'(out_instr), 64'h4006);
        cycle(0, 16'h0, 16'h0, 0, 0, 1, "t4.clean");

        // Fetch error locks the queue and is delivered
        cycle(1, 16'h4010, 16'h0600, 1, 0, 0, "t5.err");
        chk("t5.out_err", 64'(out_err), 64'd1);
        cycle(1, 16'h4011, 16'h0602, 0, 0, 0, "t5.dropped");
        cycle(0, 16'h0, 16'h0, 0, 1, 0, "t5.pop");
        cycle(0, 16'h0, 16'h0, 0, 0, 1, "t5.flush");

        // Asynchronous reset mid-cycle
        cycle(1, 16'h4300, 16'h0700, 0, 0, 0, "t6.push");
        cycle(1, 16'h4301, 16'h0702, 0, 0, 0, "t6.push");
        #2;
        rst = 1'b0;
        #1;
        mq.delete();
        m_locked = 1'b0;
        check_all("t6.async_rst");
        chk("t6.nop", 64'(out_instr), 64'h0800);
        @(negedge clk);
        rst = 1'b1;

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            rp  = ($urandom_range(0, 9) < 7);
            rpo = ($urandom_range(0, 1) == 1);
            rfl = ($urandom_range(0, 19) == 0);
            re  = ($urandom_range(0, 29) == 0);
            ri  = 16'($urandom);
            if (ri[15:11] == 5'd0 && $urandom_range(0, 3) != 0) ri[15] = 1'b1;
            cycle(rp, ri, 16'($urandom) & 16'hfffe, re, rpo, rfl, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
